// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI command arbiter: FSM encoding and default widths.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  localparam int ARB_AW_DEF = 8;
  localparam int ARB_DW_DEF = 32;
  localparam int ARB_CNT_W  = 16;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module spi_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic                    o_any,
  output logic [$clog2(NREQ)-1:0] o_grant
);

  localparam int IW = $clog2(NREQ);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest request past the pointer wins
  always_comb begin
    o_any   = |i_req;
    o_grant = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      w_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
      if (i_req[w_idx]) o_grant = w_idx;
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI transaction engine between NREQ command sources.
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = ARB_AW_DEF,
  parameter int DW      = ARB_DW_DEF,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ-1:0]  req_rw,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             eng_start,
  output logic             eng_rw,
  output logic [AW-1:0]    eng_addr,
  output logic [DW-1:0]    eng_wdata,
  input  logic             eng_busy,
  input  logic             eng_done,
  input  logic [DW-1:0]    eng_rdata
);

  localparam int IW = $clog2(NREQ);
  localparam logic [ARB_CNT_W-1:0] TMO_LIM = ARB_CNT_W'(TIMEOUT);
  localparam logic [NREQ-1:0]      ONE     = NREQ'(1);

  arb_state_e           r_state, w_state_nxt;
  logic [IW-1:0]        r_ptr, r_grant, w_pick;
  logic                 w_any;
  logic [ARB_CNT_W-1:0] r_cnt, w_cnt_inc;
  logic                 w_grant_fire, w_start_fire, w_done_fire, w_tmo_fire;
  logic [NREQ-1:0]      r_req_ready, r_rsp_valid;
  logic [DW-1:0]        r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_eng_start, r_eng_rw;
  logic [AW-1:0]        r_eng_addr;
  logic [DW-1:0]        r_eng_wdata;

  spi_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_any   (w_any),
    .o_grant (w_pick)
  );

  // Saturate so a very long busy phase cannot wrap past the limit
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_grant_fire) w_state_nxt = ARB_START;
      ARB_START: if (w_start_fire) w_state_nxt = ARB_WAIT;
      ARB_WAIT:  if (w_done_fire || w_tmo_fire) w_state_nxt = ARB_RESP;
      ARB_RESP:  w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Per-state event decode; eng_done beats a coincident timeout
  always_comb begin
    w_grant_fire = (r_state == ARB_IDLE)  && w_any;
    w_start_fire = (r_state == ARB_START) && !eng_busy;
    w_done_fire  = (r_state == ARB_WAIT)  && eng_done;
    w_tmo_fire   = (r_state == ARB_WAIT)  && !eng_done && (w_cnt_inc >= TMO_LIM);
  end

  // Command latch, handshake pulses, timeout counter, response and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_rw    <= 1'b0;
      r_eng_addr  <= '0;
      r_eng_wdata <= '0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_eng_start <= 1'b0;
      if (w_grant_fire) begin
        r_grant     <= w_pick;
        r_eng_rw    <= req_rw[w_pick];
        r_eng_addr  <= req_addr[int'(w_pick)*AW +: AW];
        r_eng_wdata <= req_wdata[int'(w_pick)*DW +: DW];
        r_req_ready <= ONE << w_pick;
        r_cnt       <= '0;
      end
      if (r_state == ARB_START || r_state == ARB_WAIT) r_cnt <= w_cnt_inc;
      if (w_start_fire) r_eng_start <= 1'b1;
      if (w_done_fire) begin
        r_rsp_rdata <= r_eng_rw ? eng_rdata : '0;
        r_rsp_err   <= 1'b0;
        r_rsp_valid <= ONE << r_grant;
      end else if (w_tmo_fire) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
        r_rsp_valid <= ONE << r_grant;
      end
      if (r_state == ARB_RESP) r_ptr <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign eng_start = r_eng_start;
  assign eng_rw    = r_eng_rw;
  assign eng_addr  = r_eng_addr;
  assign eng_wdata = r_eng_wdata;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter with a cycle-count reference model.
module tb_spi_cmd_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TMO  = 20;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_rw, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata, eng_wdata, eng_rdata;
  logic                 rsp_err, eng_start, eng_rw, eng_busy, eng_done;
  logic [AW-1:0]        eng_addr;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  always #5 clk = ~clk;

  spi_cmd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_rw    (eng_rw),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_rdata (eng_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},   64'({req_ready, rsp_valid, rsp_err, eng_start, eng_rw}), 64'd0);
    chk({tag, "_addr"},  64'(eng_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(eng_wdata), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // Round-robin rule: first requester at or after the pointer, modulo NREQ
  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if ((v & (NREQ'(1) << idx)) != '0) return idx;
    end
    return 0;
  endfunction

  // One full command. Cycle numbers count clock edges after the grant edge:
  // busy for edges 1..busy, start on edge busy+1, done raised for edge busy+2+dly
  // (dly<0: never); response at that edge, or at edge TMO if that comes first.
  task automatic run_cmd(input logic [NREQ-1:0] mask, input int busy, input int dly,
                         input logic [DW-1:0] rd);
    int              w, t_done, t_resp;
    logic            exp_err, e_rw;
    logic [NREQ-1:0] oh;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wd, e_rd;
    w       = model_pick(mask, m_ptr);
    oh      = NREQ'(1) << w;
    e_rw    = |(req_rw & oh);
    e_addr  = AW'(req_addr >> (w * AW));
    e_wd    = DW'(req_wdata >> (w * DW));
    t_done  = (dly < 0) ? (1 << 30) : busy + 2 + dly;
    t_resp  = (t_done <= TMO) ? t_done : TMO;
    exp_err = (t_done > TMO);
    e_rd    = (!exp_err && e_rw) ? rd : '0;

    req_valid = mask;
    @(posedge clk); #1;
    chk("req_ready",   64'(req_ready), 64'(oh));
    chk("start_early", 64'(eng_start), 64'd0);
    chk("eng_addr",    64'(eng_addr),  64'(e_addr));
    chk("eng_wdata",   64'(eng_wdata), 64'(e_wd));
    chk("eng_rw",      64'(eng_rw),    64'(e_rw));
    req_valid = mask & ~oh;
    eng_busy  = (busy > 0);
    for (int i = 1; i <= busy; i++) begin
      @(posedge clk); #1;
      chk("busy_hold", 64'({req_ready, eng_start}), 64'd0);
    end
    eng_busy = 1'b0;
    @(posedge clk); #1;
    chk("eng_start",  64'(eng_start), 64'd1);
    chk("ready_drop", 64'(req_ready), 64'd0);
    for (int k = busy + 2; k <= t_resp; k++) begin
      if (k == t_done) begin
        eng_done  = 1'b1;
        eng_rdata = rd;
      end
      @(posedge clk); #1;
      eng_done  = 1'b0;
      eng_rdata = $urandom;
      if (k < t_resp) chk("wait_quiet", 64'({rsp_valid, eng_start, req_ready}), 64'd0);
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_err",   64'(rsp_err),   64'(exp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
    chk("eng_stable", 64'(eng_addr), 64'(e_addr));
    m_ptr = (w + 1) % NREQ;
    @(posedge clk); #1;
    chk("rsp_clear", 64'(rsp_valid), 64'd0);
    chk("rsp_hold",  64'({rsp_err, rsp_rdata}), 64'({exp_err, e_rd}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_rdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("post_reset");

    // Single write from requester 1
    req_rw = 3'b000; req_addr = 24'h00_05_00;
    req_wdata = {32'h0, 32'h0123_4567, 32'h0};
    run_cmd(3'b010, 0, 2, 32'hDEAD_BEEF);

    // Read from requester 2
    req_rw = 3'b100; req_addr = 24'h81_00_00; req_wdata = '0;
    run_cmd(3'b100, 0, 1, 32'hAAAA_AAAA);

    // Fairness: all three requesting continuously
    for (int n = 0; n < 6; n++) begin
      req_rw    = NREQ'($urandom);
      req_addr  = (NREQ*AW)'($urandom);
      req_wdata = {$urandom, $urandom, $urandom};
      run_cmd(3'b111, 0, $urandom_range(0, 3), $urandom);
    end
    req_valid = '0;

    // Engine busy for 10 cycles after grant
    req_rw = NREQ'($urandom); req_addr = (NREQ*AW)'($urandom);
    req_wdata = {$urandom, $urandom, $urandom};
    run_cmd(3'b001, 10, 1, $urandom);

    // Timeout on a read, then a late eng_done that must be ignored
    req_rw = 3'b010; req_addr = (NREQ*AW)'($urandom);
    run_cmd(3'b010, 0, -1, $urandom);
    eng_done = 1'b1; eng_rdata = $urandom;
    @(posedge clk); #1;
    eng_done = 1'b0;
    chk("late_done", 64'({rsp_valid, req_ready, eng_start}), 64'd0);
    chk("late_err_hold", 64'(rsp_err), 64'd1);
    @(posedge clk); #1;
    chk("late_done2", 64'(rsp_valid), 64'd0);

    // eng_done on the same edge the timeout would fire
    req_rw = 3'b100;
    run_cmd(3'b100, 3, 15, 32'h5A5A_C3C3);

    // Random traffic
    for (int n = 0; n < 8; n++) begin
      req_rw    = NREQ'($urandom);
      req_addr  = (NREQ*AW)'($urandom);
      req_wdata = {$urandom, $urandom, $urandom};
      run_cmd(NREQ'($urandom_range(1, 7)), $urandom_range(0, 4), $urandom_range(0, 6), $urandom);
      req_valid = '0;
    end

    // Leave the pointer at 1, then abort a command in WAIT with reset
    run_cmd(3'b001, 0, 1, $urandom);
    req_rw = 3'b010; req_addr = 24'h00_3C_00;
    req_valid = 3'b010;
    @(posedge clk); #1;
    chk("abort_ready", 64'(req_ready), 64'b010);
    req_valid = '0;
    @(posedge clk); #1;
    chk("abort_start", 64'(eng_start), 64'd1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
    chk_zero("abort_release");
    eng_done = 1'b1; eng_rdata = $urandom;
    @(posedge clk); #1;
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_abort_rsp", 64'({rsp_valid, req_ready, eng_start}), 64'd0);
      @(posedge clk); #1;
    end
    req_rw = NREQ'($urandom); req_addr = (NREQ*AW)'($urandom);
    req_wdata = {$urandom, $urandom, $urandom};
    run_cmd(3'b111, 0, 2, $urandom);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
